// File: rtl/pc_wb_display_scanner.sv
// pc_wb_display_scanner
//   Multiplexed 8-digit hex display for a processor's PC and writeback data.
//   Update captures PCIn and WriteDataIn into two snapshots. Hold suppresses
//   the capture. Mode picks which snapshot is shown. The decimal point on
//   digit 0 flashes for FLASH_FRAMES frames after each capture.
//
// Ports
//   Clk         : system clock, rising edge
//   Reset       : asynchronous, active-low reset
//   PCIn        : PC value to capture
//   WriteDataIn : writeback data value to capture
//   Update      : one-cycle capture strobe
//   Hold        : 1 freezes both snapshots
//   Mode        : 0 shows the PC snapshot, 1 shows the WriteData snapshot
//   An          : active-low digit enables; An[0] is the least significant nibble
//   Seg         : active-low segments {g,f,e,d,c,b,a}
//   Dp          : active-low decimal point
module pc_wb_display_scanner #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned FLASH_FRAMES = 4,
    parameter bit          BLANK_LZ     = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCIn,
    input  logic [31:0] WriteDataIn,
    input  logic        Update,
    input  logic        Hold,
    input  logic        Mode,
    output logic [7:0]  An,
    output logic [6:0]  Seg,
    output logic        Dp
);

    localparam int unsigned CntW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned FlashW = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
    localparam logic [CntW-1:0]   CntMax    = CntW'(REFRESH_DIV - 1);
    localparam logic [FlashW-1:0] FlashLoad = FlashW'(FLASH_FRAMES);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        digit_q, digit_d;
    logic [31:0]       snap_pc_q, snap_pc_d;
    logic [31:0]       snap_wd_q, snap_wd_d;
    logic [FlashW-1:0] flash_q, flash_d;
    logic [7:0]        an_d;
    logic [6:0]        seg_d;
    logic              dp_d;

    logic        tick;
    logic        frame_wrap;
    logic        capture;
    logic [31:0] sel;
    logic [2:0]  msnz;
    logic        blank;

    // Timing, capture and flash bookkeeping.
    always_comb begin
        tick       = (cnt_q == CntMax);
        frame_wrap = tick && (digit_q == 3'd7);
        capture    = Update && !Hold;

        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        digit_d = tick ? digit_q + 3'd1 : digit_q;

        snap_pc_d = capture ? PCIn        : snap_pc_q;
        snap_wd_d = capture ? WriteDataIn : snap_wd_q;

        // A capture that lands on a frame wrap restarts the full flash.
        flash_d = flash_q;
        if (capture) begin
            flash_d = FlashLoad;
        end else if (frame_wrap && (flash_q != '0)) begin
            flash_d = flash_q - 1'b1;
        end
    end

    // Display outputs, decoded from the registered digit index so that An,
    // Seg and Dp always describe the same digit.
    always_comb begin
        sel  = Mode ? snap_wd_q : snap_pc_q;
        msnz = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (sel[4*i +: 4] != 4'h0) begin
                msnz = 3'(i);
            end
        end
        // msnz is never below 0, so digit 0 is never blanked.
        blank = BLANK_LZ && (digit_q > msnz);

        an_d  = ~(8'b1 << digit_q);
        seg_d = blank ? 7'h7F : hex7(sel[4*digit_q +: 4]);
        dp_d  = !((digit_q == 3'd0) && (flash_q != '0));
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q     <= '0;
            digit_q   <= 3'd0;
            snap_pc_q <= 32'h0;
            snap_wd_q <= 32'h0;
            flash_q   <= '0;
            An        <= 8'hFE;
            Seg       <= 7'h40;
            Dp        <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            snap_pc_q <= snap_pc_d;
            snap_wd_q <= snap_wd_d;
            flash_q   <= flash_d;
            An        <= an_d;
            Seg       <= seg_d;
            Dp        <= dp_d;
        end
    end

endmodule

// File: tb/tb_pc_wb_display_scanner.sv
// Bench for pc_wb_display_scanner with REFRESH_DIV=4, FLASH_FRAMES=2, BLANK_LZ=1.
module tb_pc_wb_display_scanner;

    localparam int DIV   = 4;
    localparam int FLASH = 2;
    localparam int FRAME = DIV * 8;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PCIn;
    logic [31:0] WriteDataIn;
    logic        Update;
    logic        Hold;
    logic        Mode;
    logic [7:0]  An;
    logic [6:0]  Seg;
    logic        Dp;

    always #5 Clk = ~Clk;

    pc_wb_display_scanner #(
        .REFRESH_DIV (DIV),
        .FLASH_FRAMES(FLASH),
        .BLANK_LZ    (1'b1)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .PCIn       (PCIn),
        .WriteDataIn(WriteDataIn),
        .Update     (Update),
        .Hold       (Hold),
        .Mode       (Mode),
        .An         (An),
        .Seg        (Seg),
        .Dp         (Dp)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    // segs[k] is the expected Seg for digit k; literals list digit 7 first.
    typedef struct packed {
        logic [31:0]     pc;
        logic [31:0]     wd;
        logic            mode;
        logic [7:0][6:0] segs;
    } vec_t;

    exp_t            sb[$];
    vec_t            tab[7];
    logic [6:0]      hex_tab[16];
    int              errors = 0;
    int              checks = 0;
    int              n;          // edges since reset release
    logic [31:0]     m_pc, m_wd;
    int              m_flash;
    logic            use_tab;
    logic [7:0][6:0] tab_segs;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] model_seg(input logic [31:0] v, input int d);
        int top = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[4*i +: 4] != 4'h0) top = i;
        end
        if (d > top) return 7'h7F;
        return hex_tab[v[4*d +: 4]];
    endfunction

    // Push the expectation for the coming edge, clock it, then pop and compare.
    task automatic step();
        int          d;
        logic        wrap;
        logic [31:0] sel;
        exp_t        e;
        exp_t        got;
        d      = (n / DIV) % 8;
        wrap   = ((n % DIV) == DIV - 1) && (d == 7);
        sel    = Mode ? m_wd : m_pc;
        e.an   = ~(8'b1 << d);
        e.seg  = use_tab ? tab_segs[d] : model_seg(sel, d);
        e.dp   = !((d == 0) && (m_flash != 0));
        sb.push_back(e);
        @(posedge Clk);
        #1;
        if (Update && !Hold) begin
            m_pc    = PCIn;
            m_wd    = WriteDataIn;
            m_flash = FLASH;
        end else if (wrap && m_flash > 0) begin
            m_flash--;
        end
        n++;
        got = sb.pop_front();
        check($sformatf("an@%0d", n), {24'h0, An}, {24'h0, got.an});
        check($sformatf("seg@%0d", n), {25'h0, Seg}, {25'h0, got.seg});
        check($sformatf("dp@%0d", n), {31'h0, Dp}, {31'h0, got.dp});
    endtask

    task automatic run_to_wrap();
        while ((n % FRAME) != FRAME - 1) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        tab[0] = '{32'h0040_0008, 32'h0000_0000, 1'b0,
                   {7'h7F, 7'h7F, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40, 7'h00}};
        tab[1] = '{32'h0000_0000, 32'h1234_ABCD, 1'b1,
                   {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21}};
        tab[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0,
                   {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        tab[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0,
                   {7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E}};
        tab[4] = '{32'h0000_0000, 32'h0000_0100, 1'b1,
                   {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}};
        tab[5] = '{32'h8000_0000, 32'h0000_0000, 1'b0,
                   {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        tab[6] = '{32'h0000_0001, 32'h0056_7E9F, 1'b1,
                   {7'h7F, 7'h7F, 7'h12, 7'h02, 7'h78, 7'h06, 7'h10, 7'h0E}};

        Reset = 1'b0; PCIn = 32'h0; WriteDataIn = 32'h0;
        Update = 1'b0; Hold = 1'b0; Mode = 1'b0;
        use_tab = 1'b0; tab_segs = '0;
        m_pc = 32'h0; m_wd = 32'h0; m_flash = 0; n = 0;

        // Outputs while held in reset.
        @(posedge Clk);
        #1;
        check("reset_an", {24'h0, An}, 32'hFE);
        check("reset_seg", {25'h0, Seg}, 32'h40);
        check("reset_dp", {31'h0, Dp}, 32'h1);
        Reset = 1'b1;

        // Idle scan across more than one frame.
        repeat (FRAME + 8) step();

        // Capture each vector, align to a frame start, then check a full frame.
        for (int i = 0; i < 7; i++) begin
            PCIn        = tab[i].pc;
            WriteDataIn = tab[i].wd;
            Mode        = tab[i].mode;
            Update      = 1'b1;
            step();
            Update = 1'b0;
            do step(); while ((n % FRAME) != 0);
            use_tab  = 1'b1;
            tab_segs = tab[i].segs;
            repeat (FRAME) step();
            use_tab = 1'b0;
        end

        // Let the flash expire, then an Update under Hold must change nothing.
        repeat (3 * FRAME) step();
        Mode        = 1'b1;
        Hold        = 1'b1;
        WriteDataIn = 32'hFFFF_FFFF;
        PCIn        = 32'hFFFF_FFFF;
        Update      = 1'b1;
        step();
        Update = 1'b0;
        repeat (FRAME + 8) step();
        Hold = 1'b0;
        Mode = 1'b0;

        // Capture, let one wrap bring the flash to 1, then capture on the next wrap.
        PCIn   = 32'h0000_0023;
        Update = 1'b1;
        step();
        Update = 1'b0;
        run_to_wrap();
        step();
        run_to_wrap();
        PCIn   = 32'h0000_0123;
        Update = 1'b1;
        step();
        Update = 1'b0;
        repeat (2 * FRAME + 8) step();

        // Start a fresh flash, then pulse reset in the middle of digit 5.
        PCIn   = 32'hDEAD_BEEF;
        Update = 1'b1;
        step();
        Update = 1'b0;
        for (int k = 0; k < 2 * FRAME && !(((n / DIV) % 8) == 5 && (n % DIV) == 2); k++) step();
        #1;
        Reset = 1'b0;
        #1;
        check("midreset_an", {24'h0, An}, 32'hFE);
        check("midreset_seg", {25'h0, Seg}, 32'h40);
        check("midreset_dp", {31'h0, Dp}, 32'h1);
        #2;
        Reset = 1'b1;
        n = 0; m_pc = 32'h0; m_wd = 32'h0; m_flash = 0;
        repeat (FRAME + 8) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_wb_display_scanner.md
PC_WB_DISPLAY_SCANNER -- requirements
Module: pc_wb_display_scanner

Interface
REQ-001 The block SHALL take these parameters:
- REFRESH_DIV, 100000: clocks per digit slot (minimum 2).
- FLASH_FRAMES, 4: full 8-digit frames for which the update indicator stays lit.
- BLANK_LZ, 1: 1 blanks leading zero digits.

REQ-002 The block SHALL have these ports, clock and reset first:
- Clk, input, 1: single system clock; all state changes on its rising edge.
- Reset, input, 1: asynchronous, active-low reset.
- PCIn, input, 32: processor PC display value.
- WriteDataIn, input, 32: processor writeback data display value.
- Update, input, 1: 1-cycle strobe from the processor on writeback.
- Hold, input, 1: 1 freezes both snapshots.
- Mode, input, 1: 0 shows the PC snapshot, 1 shows the WriteData snapshot.
- An, output, 8: active-low digit enables; An[0] is the least significant nibble.
- Seg, output, 7: active-low segments, bit order {g,f,e,d,c,b,a}.
- Dp, output, 1: active-low decimal point.

REQ-003 All outputs SHALL be registered; no output SHALL be combinational from inputs.

Function
REQ-004 The tick counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick is asserted in the cycle where count == REFRESH_DIV-1.
REQ-005 The digit index (3 bits) SHALL increment on each tick edge and wrap 7->0.
REQ-006 A frame-wrap event SHALL be a tick while the digit index is 7.
REQ-007 Capture: on an edge with Update=1 and Hold=0, PCIn and WriteDataIn SHALL load into snapPC and snapWD simultaneously.
REQ-008 If Update=1 and Hold=1, the Update SHALL be ignored entirely, with no capture and no flash.
REQ-009 On every edge, An SHALL be ~(8'b1 << digit).
REQ-010 On every edge, Seg SHALL be the hex decode of the selected snapshot nibble [4*digit+3 : 4*digit].
- The selected snapshot is snapPC when Mode=0 and snapWD when Mode=1.
- An and Seg therefore reflect the same registered digit index.
- Seg reflects a new snapshot or Mode value exactly 1 cycle after the capture or Mode change edge.
REQ-011 The hex decode SHALL use the standard 7-segment table, with these anchor values:
- 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30.
- 8=7'h00, A=7'h08, F=7'h0E.
REQ-012 Blanking: with BLANK_LZ=1, a digit above the most significant nonzero nibble SHALL drive Seg=7'h7F.
- Digit 0 SHALL never be blanked, so a zero value shows a single "0".
REQ-013 Flash counter behaviour:
- A capture SHALL load the flash counter with FLASH_FRAMES.
- Each frame-wrap SHALL decrement it while it is nonzero, saturating at 0.
- If a capture and a frame-wrap occur on the same edge, the load SHALL win.
REQ-014 Dp SHALL be 0 (lit) only when the digit index is 0 and the flash counter is nonzero; otherwise Dp SHALL be 1.
REQ-015 Neither Mode nor Hold SHALL affect the tick counter, the digit index, or the flash counter.

Reset
REQ-016 Reset=0 SHALL asynchronously clear the tick counter, digit index, snapPC, snapWD and the flash counter.
REQ-017 During reset and on the first edge after release, the outputs SHALL be An=8'hFE, Seg=7'h40 and Dp=1.
REQ-018 A reset asserted mid-frame or mid-flash SHALL abort the frame or flash immediately, with no residual flash.

Verification (REFRESH_DIV=4, FLASH_FRAMES=2, BLANK_LZ=1)
REQ-019 Reset release with no Update -> An steps FE, FD, FB ... 7F, FE, with each step every 4 clocks; Seg=7'h40 on digit 0 and 7'h7F on all other digits; Dp=1 throughout.
REQ-020 Update with PCIn=32'h0040_0008 and Mode=0 -> Seg shows 8 (7'h00) on digit 0, 0 on digits 1-4, 4 (7'h19) on digit 5, and blank on digits 6-7.
REQ-021 Update with PCIn=32'h0040_0008 and Mode=0 -> Dp=0 on digit 0 for exactly 2 frames, then Dp=1.
REQ-022 Hold=1 together with Update carrying WriteDataIn=32'hFFFF_FFFF, then Mode=1 -> the display keeps the prior snapWD value and Dp stays 1.
REQ-023 Update on the same edge as a frame-wrap while the flash counter is 1 -> the flash counter becomes 2, not 0.
REQ-024 Reset pulsed low for 3 ns in the middle of digit 5 -> An=8'hFE and Seg=7'h40 immediately; the tick counter restarts from 0.
